// File: rtl/tank_shell.sv
// Per-player shell controller: spawns a shell from the tank centre on a fire
// press, advances it one step per frame, and retires it on the screen edge,
// a wall tile or the enemy tank, followed by a fixed reload cooldown.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   S_IDLE     | no shell in flight; a fire edge spawns one
//   S_FLY      | shell moving along shot_dir_q; checks edge/enemy/wall
//   S_COOLDOWN | shell retired; cool_cnt counts down to 0, then S_IDLE
module tank_shell #(
    parameter logic [9:0] SHELL_STEP      = 10'd4,
    parameter logic [9:0] SHELL_SIZE      = 10'd8,
    parameter logic [9:0] TANK_SIZE       = 10'd32,
    parameter logic [5:0] COOLDOWN_FRAMES = 6'd30,
    parameter logic [9:0] SCREEN_W        = 10'd640,
    parameter logic [9:0] SCREEN_H        = 10'd480
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       player,
    input  logic [7:0] keycode,
    input  logic [9:0] TankX,
    input  logic [9:0] TankY,
    input  logic [9:0] EnemyX,
    input  logic [9:0] EnemyY,
    input  logic       TileSolid,
    output logic [8:0] TileIdx,
    output logic [9:0] ShellX,
    output logic [9:0] ShellY,
    output logic       ShellActive,
    output logic       Hit
);

    typedef enum logic [1:0] {S_IDLE, S_FLY, S_COOLDOWN} state_t;
    typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

    localparam logic [7:0] P1_UP    = 8'h1A;
    localparam logic [7:0] P1_DOWN  = 8'h16;
    localparam logic [7:0] P1_LEFT  = 8'h04;
    localparam logic [7:0] P1_RIGHT = 8'h07;
    localparam logic [7:0] P1_FIRE  = 8'h2C;
    localparam logic [7:0] P2_UP    = 8'h52;
    localparam logic [7:0] P2_DOWN  = 8'h51;
    localparam logic [7:0] P2_LEFT  = 8'h4F;
    localparam logic [7:0] P2_RIGHT = 8'h50;
    localparam logic [7:0] P2_FIRE  = 8'h28;

    // Shell spawns centred on the tank; its centre point is used for map/hit.
    localparam logic [9:0] SPAWN_OFS  = (TANK_SIZE - SHELL_SIZE) >> 1;
    localparam logic [9:0] SHELL_HALF = SHELL_SIZE >> 1;
    localparam logic [9:0] X_MAX      = SCREEN_W - SHELL_SIZE;
    localparam logic [9:0] Y_MAX      = SCREEN_H - SHELL_SIZE;

    state_t     state_q, state_d;
    dir_t       dir_q, dir_d, shot_dir_q;
    logic       fire, fire_prev, fire_edge;
    logic [5:0] cool_cnt;
    logic [9:0] cand_x, cand_y, cx, cy;
    logic       oob, enemy_hit;
    logic       spawn, move, stop, hit_now;
    logic [10:0] enemy_x_hi, enemy_y_hi;

    // Direction decode from the player's key map; unknown keys hold direction.
    always_comb begin
        dir_d = dir_q;
        if (player) begin
            case (keycode)
                P1_UP:    dir_d = D_UP;
                P1_DOWN:  dir_d = D_DOWN;
                P1_LEFT:  dir_d = D_LEFT;
                P1_RIGHT: dir_d = D_RIGHT;
                default:  dir_d = dir_q;
            endcase
        end else begin
            case (keycode)
                P2_UP:    dir_d = D_UP;
                P2_DOWN:  dir_d = D_DOWN;
                P2_LEFT:  dir_d = D_LEFT;
                P2_RIGHT: dir_d = D_RIGHT;
                default:  dir_d = dir_q;
            endcase
        end
    end

    assign fire      = (keycode == (player ? P1_FIRE : P2_FIRE));
    assign fire_edge = fire & ~fire_prev;

    // Candidate next position and edge test; LEFT/UP test before subtracting
    // so the 10-bit position can never wrap.
    always_comb begin
        cand_x = ShellX;
        cand_y = ShellY;
        oob    = 1'b0;
        case (shot_dir_q)
            D_UP: begin
                cand_y = ShellY - SHELL_STEP;
                oob    = (ShellY < SHELL_STEP);
            end
            D_DOWN: begin
                cand_y = ShellY + SHELL_STEP;
                oob    = (cand_y > Y_MAX);
            end
            D_LEFT: begin
                cand_x = ShellX - SHELL_STEP;
                oob    = (ShellX < SHELL_STEP);
            end
            default: begin
                cand_x = ShellX + SHELL_STEP;
                oob    = (cand_x > X_MAX);
            end
        endcase
    end

    assign cx = cand_x + SHELL_HALF;
    assign cy = cand_y + SHELL_HALF;

    // Hit box upper bounds in 11 bits so an enemy near the edge cannot wrap.
    assign enemy_x_hi = {1'b0, EnemyX} + {1'b0, TANK_SIZE} - 11'd1;
    assign enemy_y_hi = {1'b0, EnemyY} + {1'b0, TANK_SIZE} - 11'd1;
    assign enemy_hit  = (cx >= EnemyX) && ({1'b0, cx} <= enemy_x_hi) &&
                        (cy >= EnemyY) && ({1'b0, cy} <= enemy_y_hi);

    // Map query for the tile holding the candidate centre (20 tiles per row).
    always_comb begin
        TileIdx = 9'd0;
        if (state_q == S_FLY && !oob) begin
            TileIdx = ({4'd0, cy[9:5]} * 9'd20) + {4'd0, cx[9:5]};
        end
    end

    // Next-state and per-cycle actions; edge beats enemy beats wall.
    always_comb begin
        state_d = state_q;
        spawn   = 1'b0;
        move    = 1'b0;
        stop    = 1'b0;
        hit_now = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fire_edge) begin
                    spawn   = 1'b1;
                    state_d = S_FLY;
                end
            end
            S_FLY: begin
                if (oob) begin
                    stop    = 1'b1;
                    state_d = S_COOLDOWN;
                end else if (enemy_hit) begin
                    stop    = 1'b1;
                    hit_now = 1'b1;
                    state_d = S_COOLDOWN;
                end else if (TileSolid) begin
                    stop    = 1'b1;
                    state_d = S_COOLDOWN;
                end else begin
                    move = 1'b1;
                end
            end
            S_COOLDOWN: begin
                if (cool_cnt == 6'd0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Shell datapath, direction latches, fire history and cooldown timer.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            dir_q       <= player ? D_UP : D_DOWN;
            shot_dir_q  <= player ? D_UP : D_DOWN;
            fire_prev   <= 1'b0;
            ShellX      <= 10'd0;
            ShellY      <= 10'd0;
            ShellActive <= 1'b0;
            Hit         <= 1'b0;
            cool_cnt    <= 6'd0;
        end else begin
            dir_q     <= dir_d;
            fire_prev <= fire;
            Hit       <= hit_now;
            if (spawn) begin
                ShellX      <= TankX + SPAWN_OFS;
                ShellY      <= TankY + SPAWN_OFS;
                ShellActive <= 1'b1;
                shot_dir_q  <= dir_q;
            end
            if (move) begin
                ShellX <= cand_x;
                ShellY <= cand_y;
            end
            if (stop) begin
                ShellActive <= 1'b0;
                cool_cnt    <= COOLDOWN_FRAMES - 6'd1;
            end else if (state_q == S_COOLDOWN && cool_cnt != 6'd0) begin
                cool_cnt <= cool_cnt - 6'd1;
            end
        end
    end

endmodule

// File: tb/tb_tank_shell.sv
// Directed bench for tank_shell: a table of single-frame vectors covering
// spawn, travel, wall stop, enemy hit and reset, plus hand sequences for the
// screen-edge retire and the exact cooldown length.
module tb_tank_shell;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic       player;
    logic [7:0] keycode;
    logic [9:0] TankX, TankY, EnemyX, EnemyY;
    logic       TileSolid;
    logic [8:0] TileIdx;
    logic [9:0] ShellX, ShellY;
    logic       ShellActive, Hit;

    int n_vec = 0;
    int n_err = 0;

    tank_shell dut (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .player      (player),
        .keycode     (keycode),
        .TankX       (TankX),
        .TankY       (TankY),
        .EnemyX      (EnemyX),
        .EnemyY      (EnemyY),
        .TileSolid   (TileSolid),
        .TileIdx     (TileIdx),
        .ShellX      (ShellX),
        .ShellY      (ShellY),
        .ShellActive (ShellActive),
        .Hit         (Hit)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        logic       rst;
        logic       ply;
        logic [7:0] key;
        logic [9:0] tx, ty, ex, ey;
        logic       solid;
        logic [9:0] sx, sy;
        logic       act, hit;
        logic [8:0] tidx;
    } vec_t;

    vec_t vecs[$];
    vec_t v;

    function automatic vec_t mk(input logic rst, input logic ply, input logic [7:0] key,
                                input logic [9:0] tx, input logic [9:0] ty,
                                input logic [9:0] ex, input logic [9:0] ey,
                                input logic solid, input logic [9:0] sx, input logic [9:0] sy,
                                input logic act, input logic hit, input logic [8:0] tidx);
        vec_t r;
        r.rst = rst; r.ply = ply; r.key = key;
        r.tx = tx; r.ty = ty; r.ex = ex; r.ey = ey; r.solid = solid;
        r.sx = sx; r.sy = sy; r.act = act; r.hit = hit; r.tidx = tidx;
        return r;
    endfunction

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    initial begin
        Reset = 1'b1; player = 1'b1; keycode = 8'h00;
        TankX = 10'd0; TankY = 10'd0; EnemyX = 10'd600; EnemyY = 10'd0;
        TileSolid = 1'b0;

        // A: player 1 fires UP, hold gives one shot, wall tile stops the shell.
        vecs.push_back(mk(1, 1, 8'h00, 32, 416, 600, 0, 0,  0,   0, 0, 0,   0));
        vecs.push_back(mk(0, 1, 8'h1A, 32, 416, 600, 0, 0,  0,   0, 0, 0,   0));
        vecs.push_back(mk(0, 1, 8'h2C, 32, 416, 600, 0, 0, 44, 428, 1, 0, 261));
        vecs.push_back(mk(0, 1, 8'h2C, 32, 416, 600, 0, 0, 44, 424, 1, 0, 261));
        vecs.push_back(mk(0, 1, 8'h2C, 32, 416, 600, 0, 0, 44, 420, 1, 0, 261));
        vecs.push_back(mk(0, 1, 8'h00, 32, 416, 600, 0, 0, 44, 416, 1, 0, 261));
        vecs.push_back(mk(0, 1, 8'h2C, 32, 416, 600, 0, 0, 44, 412, 1, 0, 241));
        vecs.push_back(mk(0, 1, 8'h00, 32, 416, 600, 0, 1, 44, 412, 0, 0,   0));
        vecs.push_back(mk(0, 1, 8'h2C, 32, 416, 600, 0, 0, 44, 412, 0, 0,   0));
        // B: shell RIGHT into enemy at (64,416); one-cycle Hit pulse.
        vecs.push_back(mk(1, 1, 8'h00, 32, 416, 64, 416, 0,  0,   0, 0, 0,   0));
        vecs.push_back(mk(0, 1, 8'h07, 32, 416, 64, 416, 0,  0,   0, 0, 0,   0));
        vecs.push_back(mk(0, 1, 8'h2C, 32, 416, 64, 416, 0, 44, 428, 1, 0, 261));
        vecs.push_back(mk(0, 1, 8'h2C, 32, 416, 64, 416, 0, 48, 428, 1, 0, 261));
        vecs.push_back(mk(0, 1, 8'h00, 32, 416, 64, 416, 0, 52, 428, 1, 0, 261));
        vecs.push_back(mk(0, 1, 8'h00, 32, 416, 64, 416, 0, 56, 428, 1, 0, 262));
        vecs.push_back(mk(0, 1, 8'h00, 32, 416, 64, 416, 0, 56, 428, 0, 1,   0));
        vecs.push_back(mk(0, 1, 8'h00, 32, 416, 64, 416, 0, 56, 428, 0, 0,   0));
        // C: player 2 arrows RIGHT + enter, reset mid-flight, then default DOWN.
        vecs.push_back(mk(1, 0, 8'h00, 100, 200, 500, 0, 0,   0,   0, 0, 0,   0));
        vecs.push_back(mk(0, 0, 8'h50, 100, 200, 500, 0, 0,   0,   0, 0, 0,   0));
        vecs.push_back(mk(0, 0, 8'h28, 100, 200, 500, 0, 0, 112, 212, 1, 0, 123));
        vecs.push_back(mk(0, 0, 8'h00, 100, 200, 500, 0, 0, 116, 212, 1, 0, 123));
        vecs.push_back(mk(1, 0, 8'h00, 100, 200, 500, 0, 0,   0,   0, 0, 0,   0));
        vecs.push_back(mk(0, 0, 8'h28, 100, 200, 500, 0, 0, 112, 212, 1, 0, 123));
        vecs.push_back(mk(0, 0, 8'h28, 100, 200, 500, 0, 0, 112, 216, 1, 0, 143));
        vecs.push_back(mk(0, 0, 8'h51, 100, 200, 500, 0, 0, 112, 220, 1, 0, 143));

        foreach (vecs[i]) begin
            v = vecs[i];
            Reset = v.rst; player = v.ply; keycode = v.key;
            TankX = v.tx; TankY = v.ty; EnemyX = v.ex; EnemyY = v.ey;
            TileSolid = v.solid;
            tick();
            n_vec++;
            if ({ShellX, ShellY, ShellActive, Hit, TileIdx} !== {v.sx, v.sy, v.act, v.hit, v.tidx}) begin
                n_err++;
                $display("FAIL vec_row%0d: got X=%0d Y=%0d act=%0b hit=%0b tile=%0d, required X=%0d Y=%0d act=%0b hit=%0b tile=%0d",
                         i, ShellX, ShellY, ShellActive, Hit, TileIdx,
                         v.sx, v.sy, v.act, v.hit, v.tidx);
            end
        end

        // D: RIGHT to the screen edge, then cooldown must last exactly 30 frames.
        Reset = 1'b1; player = 1'b1; keycode = 8'h00;
        TankX = 10'd600; TankY = 10'd100; EnemyX = 10'd0; EnemyY = 10'd300;
        TileSolid = 1'b0;
        tick();
        Reset = 1'b0; keycode = 8'h07;
        tick();
        keycode = 8'h2C;
        tick();
        chk("d_spawn_x", ShellX, 612);
        chk("d_spawn_y", ShellY, 112);
        keycode = 8'h00;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("d_move_x", ShellX, 612 + 4 * i);
            if (i == 4) chk("d_tile_628", TileIdx, 79);
        end
        chk("d_tile_oob", TileIdx, 0);
        chk("d_active_at_632", ShellActive, 1);
        tick();
        chk("d_oob_active", ShellActive, 0);
        chk("d_oob_hold_x", ShellX, 632);
        chk("d_oob_hit", Hit, 0);
        for (int k = 1; k <= 29; k++) begin
            tick();
            chk("d_cool_active", ShellActive, 0);
        end
        keycode = 8'h2C;
        tick();
        chk("d_fire_last_cool", ShellActive, 0);
        keycode = 8'h00;
        tick();
        chk("d_idle_no_fire", ShellActive, 0);
        keycode = 8'h2C;
        tick();
        chk("d_respawn_active", ShellActive, 1);
        chk("d_respawn_x", ShellX, 612);
        chk("d_respawn_y", ShellY, 112);

        // E: wall stop, fire at counter=10 ignored, IDLE exactly 30 frames later.
        keycode = 8'h00; TileSolid = 1'b1;
        tick();
        chk("e_wall_active", ShellActive, 0);
        chk("e_wall_x", ShellX, 612);
        chk("e_wall_hit", Hit, 0);
        TileSolid = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            keycode = (k == 20) ? 8'h2C : 8'h00;
            tick();
            chk("e_cool_active", ShellActive, 0);
            if (k == 20) chk("e_cool_hold_x", ShellX, 612);
        end
        keycode = 8'h2C;
        tick();
        chk("e_spawn_after_cool", ShellActive, 1);
        chk("e_spawn_x", ShellX, 612);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
